// File: rtl/one_to_n_demux_stream.sv
// One-to-N stream demultiplexer.
// Each input word is routed either to a single output channel or, as a
// broadcast, to every channel at once. Each channel has a one-entry
// holding register. A channel may be drained and refilled on the same edge.
// A broadcast is accepted only when every channel can take the word,
// so a broadcast never reaches only some of the channels.
module one_to_n_demux_stream #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [WIDTH-1:0]                in_data,
    input  logic [SEL_W-1:0]                in_sel,
    input  logic                            in_bcast,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [(2**SEL_W)*WIDTH-1:0]     out_data,
    output logic [(2**SEL_W)-1:0]           out_valid,
    input  logic [(2**SEL_W)-1:0]           out_ready,
    output logic [15:0]                     xfer_count
);

    localparam int NUM_CH = 2**SEL_W;

    logic [NUM_CH-1:0][WIDTH-1:0] data_r;
    logic [NUM_CH-1:0]            full_r;
    logic [15:0]                  count_r;

    logic [NUM_CH-1:0]            free_s;
    logic [NUM_CH-1:0]            load_s;
    logic                         ready_s;
    logic                         accept_s;

    // A channel is free when it is empty or its consumer takes the word this cycle
    always_comb begin
        free_s = ~full_r | out_ready;
    end

    // Ready depends on every channel for a broadcast, else only on the selected one
    always_comb begin
        ready_s = 1'b0;
        if (in_bcast) begin
            ready_s = &free_s;
        end else begin
            ready_s = free_s[in_sel];
        end
    end

    // Decode which holding registers load on this edge
    always_comb begin
        load_s   = '0;
        accept_s = in_valid & ready_s;
        for (int k = 0; k < NUM_CH; k++) begin
            if (accept_s && (in_bcast || (in_sel == SEL_W'(k)))) begin
                load_s[k] = 1'b1;
            end else begin
                load_s[k] = 1'b0;
            end
        end
    end

    // Per-channel holding registers: a load wins over a drain; a drained word keeps its data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= '0;
            full_r <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (load_s[k]) begin
                    data_r[k] <= in_data;
                    full_r[k] <= 1'b1;
                end else if (full_r[k] && out_ready[k]) begin
                    full_r[k] <= 1'b0;
                end else begin
                    full_r[k] <= full_r[k];
                end
            end
        end
    end

    // Count accepted input words; a broadcast counts once, and the count wraps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_r <= 16'd0;
        end else if (accept_s) begin
            count_r <= count_r + 16'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign in_ready   = ready_s;
    assign out_data   = data_r;
    assign out_valid  = full_r;
    assign xfer_count = count_r;

endmodule

// File: tb/tb_one_to_n_demux_stream.sv
// Directed self-checking bench for one_to_n_demux_stream with default parameters.
module tb_one_to_n_demux_stream;

    logic        clk;
    logic        reset_n;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] xfer_count;

    int checks;
    int errors;
    logic stall_seen;

    one_to_n_demux_stream #(.WIDTH(8), .SEL_W(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_bcast   (in_bcast),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .xfer_count (xfer_count)
    );

    // 10 time-unit clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        stall_seen = 1'b0;
        reset_n    = 1'b0;
        in_data    = 8'h00;
        in_sel     = 2'd0;
        in_bcast   = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 4'b0000;

        // Reset state before any clock edge
        #2;
        check("rst_valid", 64'(out_valid), 64'h0);
        check("rst_data", 64'(out_data), 64'h0);
        check("rst_count", 64'(xfer_count), 64'h0);
        check("rst_ready", 64'(in_ready), 64'h1);
        #1 reset_n = 1'b1;
        tick();

        // Unicast fill of channel 2
        in_sel = 2'd2; in_data = 8'hA5; in_valid = 1'b1;
        #1 check("uc_ready_pre", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        #1;
        check("uc_valid", 64'(out_valid), 64'h4);
        check("uc_slice2", 64'(out_data[16 +: 8]), 64'hA5);
        check("uc_count", 64'(xfer_count), 64'h1);
        check("uc_ready_sel2", 64'(in_ready), 64'h0);
        in_sel = 2'd0;
        #1 check("uc_ready_sel0", 64'(in_ready), 64'h1);

        // Drain channel 2: free again combinationally, data held after drain
        in_sel = 2'd2; out_ready = 4'b0100;
        #1 check("drain_ready", 64'(in_ready), 64'h1);
        tick();
        out_ready = 4'b0000;
        #1;
        check("drain_valid", 64'(out_valid), 64'h0);
        check("drain_hold", 64'(out_data[16 +: 8]), 64'hA5);

        // Backpressure then simultaneous drain and refill on channel 1
        in_sel = 2'd1; in_data = 8'h11; in_valid = 1'b1;
        tick();
        in_data = 8'h22;
        #1 check("bp_ready", 64'(in_ready), 64'h0);
        tick();
        check("bp_slice1", 64'(out_data[8 +: 8]), 64'h11);
        check("bp_count", 64'(xfer_count), 64'h2);
        check("bp_valid", 64'(out_valid), 64'h2);
        out_ready = 4'b0010;
        #1 check("refill_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        #1;
        check("refill_valid", 64'(out_valid), 64'h2);
        check("refill_slice1", 64'(out_data[8 +: 8]), 64'h22);
        check("refill_count", 64'(xfer_count), 64'h3);
        tick();
        out_ready = 4'b0000;
        #1 check("refill_drained", 64'(out_valid), 64'h0);

        // Broadcast into empty channels
        in_bcast = 1'b1; in_data = 8'h3C; in_valid = 1'b1;
        #1 check("bc_ready", 64'(in_ready), 64'h1);
        tick();
        in_valid = 1'b0;
        #1;
        check("bc_valid", 64'(out_valid), 64'hF);
        check("bc_data", 64'(out_data), 64'h3C3C3C3C);
        check("bc_count", 64'(xfer_count), 64'h4);
        out_ready = 4'b1110;
        tick();
        out_ready = 4'b0000;
        #1 check("bc_partial_drain", 64'(out_valid), 64'h1);

        // Broadcast blocked while channel 0 is still full
        in_data = 8'h77; in_valid = 1'b1; in_sel = 2'd3;
        #1 check("bc_blocked_ready", 64'(in_ready), 64'h0);
        tick();
        in_valid = 1'b0; in_bcast = 1'b0;
        #1;
        check("bc_blocked_valid", 64'(out_valid), 64'h1);
        check("bc_blocked_data", 64'(out_data), 64'h3C3C3C3C);
        check("bc_blocked_count", 64'(xfer_count), 64'h4);

        // Fill channels 0 (refill over drain) and 3, then async reset between edges
        out_ready = 4'b0001; in_sel = 2'd0; in_data = 8'h5A; in_valid = 1'b1;
        tick();
        out_ready = 4'b0000; in_sel = 2'd3; in_data = 8'hC3;
        tick();
        in_valid = 1'b0;
        #1;
        check("pre_rst_valid", 64'(out_valid), 64'h9);
        check("pre_rst_data", 64'(out_data), 64'hC33C3C5A);
        check("pre_rst_count", 64'(xfer_count), 64'h6);
        #1 reset_n = 1'b0;
        #1;
        check("arst_valid", 64'(out_valid), 64'h0);
        check("arst_data", 64'(out_data), 64'h0);
        check("arst_count", 64'(xfer_count), 64'h0);
        check("arst_ready", 64'(in_ready), 64'h1);
        #1 reset_n = 1'b1;

        // First acceptance on the first edge after reset release
        in_sel = 2'd3; in_data = 8'h99; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check("post_rst_valid", 64'(out_valid), 64'h8);
        check("post_rst_count", 64'(xfer_count), 64'h1);

        // Counter wrap: 65536 round-robin words from a fresh reset
        reset_n = 1'b0;
        #1 reset_n = 1'b1;
        out_ready = 4'b1111; in_valid = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            in_sel  = i[1:0];
            in_data = i[7:0];
            #1;
            if (in_ready !== 1'b1) stall_seen = 1'b1;
            tick();
            if (i == 65534) check("wrap_ffff", 64'(xfer_count), 64'hFFFF);
        end
        in_valid = 1'b0;
        #1;
        check("wrap_no_stall", 64'(stall_seen), 64'h0);
        check("wrap_count", 64'(xfer_count), 64'h0);
        check("wrap_last_valid", 64'(out_valid), 64'h8);
        check("wrap_last_data", 64'(out_data[24 +: 8]), 64'hFF);
        tick();
        check("wrap_drained", 64'(out_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
